// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - data-memory port arbiter between the M stage and a DMA requester
module dm_port_arbiter #(
    parameter int MAX_DMA_BURST = 4,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteen,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic        dma_last,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_byteen,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_rdata,
    output logic        owner
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(MAX_DMA_BURST + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_DMA_BURST);

    typedef enum logic {
        CPU_OWN   = 1'b0,
        DMA_BURST = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [SW-1:0] starve_cnt, starve_n;
    logic [BW-1:0] burst_cnt, burst_n, burst_inc;
    logic          cpu_win, dma_win, force_dma;

    assign burst_inc = burst_cnt + 1'b1;
    assign force_dma = dma_req && (starve_cnt == STARVE_MAX);

    // State and counters; reset abandons any burst in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CPU_OWN;
            starve_cnt <= '0;
            burst_cnt  <= '0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_n;
            burst_cnt  <= burst_n;
        end
    end

    // Grant decision; an abandoned burst (dma_req low) arbitrates as CPU_OWN
    always_comb begin
        cpu_win = 1'b0;
        dma_win = 1'b0;
        if (state == DMA_BURST && dma_req) begin
            dma_win = 1'b1;
        end else if (cpu_req && !force_dma) begin
            cpu_win = 1'b1;
        end else if (dma_req) begin
            dma_win = 1'b1;
        end
    end

    // Next state and counter updates
    always_comb begin
        state_n  = CPU_OWN;
        starve_n = starve_cnt;
        burst_n  = '0;
        if (state == DMA_BURST && dma_req) begin
            if (dma_last || burst_inc == BURST_MAX) begin
                state_n = CPU_OWN;
                burst_n = '0;
            end else begin
                state_n = DMA_BURST;
                burst_n = burst_inc;
            end
        end else if (cpu_win) begin
            if (dma_req) begin
                starve_n = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
            end else begin
                starve_n = '0;
            end
        end else if (dma_win) begin
            starve_n = '0;
            if (dma_last || MAX_DMA_BURST == 1) begin
                state_n = CPU_OWN;
            end else begin
                state_n = DMA_BURST;
                burst_n = BW'(1);
            end
        end else begin
            starve_n = '0;
        end
    end

    // Port mux and grant outputs, all forced idle while reset is held
    always_comb begin
        cpu_gnt       = cpu_win && !reset;
        dma_gnt       = dma_win && !reset;
        cpu_stall     = cpu_req && !cpu_gnt && !reset;
        m_data_addr   = '0;
        m_data_wdata  = '0;
        m_data_byteen = '0;
        if (cpu_gnt) begin
            m_data_addr   = cpu_addr;
            m_data_wdata  = cpu_wdata;
            m_data_byteen = cpu_we ? cpu_byteen : 4'b0000;
        end else if (dma_gnt) begin
            m_data_addr   = dma_addr;
            m_data_wdata  = dma_wdata;
            m_data_byteen = dma_we ? dma_byteen : 4'b0000;
        end
    end

    assign cpu_rdata = m_data_rdata;
    assign dma_rdata = m_data_rdata;
    assign owner     = state;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - directed-vector bench for dm_port_arbiter
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_byteen;
    logic        cpu_gnt, cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we, dma_last;
    logic [31:0] dma_addr, dma_wdata;
    logic [3:0]  dma_byteen;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic [31:0] m_data_addr, m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_rdata;
    logic        owner;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign m_data_rdata = m_data_addr ^ 32'hA5A5_0000;

    dm_port_arbiter #(.MAX_DMA_BURST(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_byteen(cpu_byteen),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_byteen(dma_byteen),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_data_rdata(m_data_rdata),
        .owner(owner)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic cg, input logic dg, input logic st, input logic ow);
        chk({tag, ".cpu_gnt"}, {31'd0, cpu_gnt}, {31'd0, cg});
        chk({tag, ".dma_gnt"}, {31'd0, dma_gnt}, {31'd0, dg});
        chk({tag, ".stall"},   {31'd0, cpu_stall}, {31'd0, st});
        chk({tag, ".owner"},   {31'd0, owner}, {31'd0, ow});
    endtask

    task automatic chk_port(input string tag, input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
        chk({tag, ".addr"},   m_data_addr, a);
        chk({tag, ".wdata"},  m_data_wdata, w);
        chk({tag, ".byteen"}, {28'd0, m_data_byteen}, {28'd0, be});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset      = 1'b1;
        cpu_req    = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0010;
        cpu_wdata  = 32'h1111_2222; cpu_byteen = 4'hF;
        dma_req    = 1'b1; dma_we = 1'b1; dma_last = 1'b0;
        dma_addr   = 32'h0000_0020; dma_wdata = 32'h3333_4444; dma_byteen = 4'hF;
        settle();
        chk_gnt("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_port("rst", 32'h0, 32'h0, 4'h0);

        // release: CPU wins with starve_cnt=0
        reset = 1'b0;
        settle();
        chk_gnt("rel", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();

        // CPU partial store with DMA idle
        dma_req = 1'b0;
        cpu_addr = 32'h0000_0100; cpu_wdata = 32'hDEAD_BEEF; cpu_byteen = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_gnt("st", 1'b1, 1'b0, 1'b0, 1'b0);
            chk_port("st", 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011);
            chk("st.rdata", cpu_rdata, 32'hA5A5_0100);
            tick();
        end
        // CPU load: byte enables suppressed
        cpu_we = 1'b0;
        settle();
        chk_port("ld", 32'h0000_0100, 32'hDEAD_BEEF, 4'b0000);
        tick();

        // starvation: 8 CPU grants, forced DMA, then CPU again
        cpu_addr = 32'h0000_0200;
        dma_req = 1'b1; dma_we = 1'b1; dma_last = 1'b1;
        dma_addr = 32'h0000_0300; dma_wdata = 32'h1234_5678; dma_byteen = 4'hF;
        for (int i = 1; i <= 8; i++) begin
            settle();
            chk_gnt($sformatf("sv%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        settle();
        chk_gnt("sv9", 1'b0, 1'b1, 1'b1, 1'b0);
        chk_port("sv9", 32'h0000_0300, 32'h1234_5678, 4'hF);
        chk("sv9.drdata", dma_rdata, 32'hA5A5_0300);
        tick();
        settle();
        chk_gnt("sv10", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();

        // idle port
        cpu_req = 1'b0; dma_req = 1'b0; dma_last = 1'b0;
        settle();
        chk_gnt("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_port("idle", 32'h0, 32'h0, 4'h0);
        tick();

        // 6-beat DMA read burst, capped at 4, CPU arrives on beat 2
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_0500;
        settle();
        chk_gnt("b1", 1'b0, 1'b1, 1'b0, 1'b0);
        chk_port("b1", 32'h0000_0500, 32'h1234_5678, 4'h0);
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0400;
        cpu_wdata = 32'hCAFE_F00D; cpu_byteen = 4'hF;
        for (int i = 2; i <= 4; i++) begin
            settle();
            chk_gnt($sformatf("b%0d", i), 1'b0, 1'b1, 1'b1, 1'b1);
            tick();
        end
        settle();
        chk_gnt("bcpu", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_port("bcpu", 32'h0000_0400, 32'hCAFE_F00D, 4'hF);
        tick();
        cpu_req = 1'b0;
        settle();
        chk_gnt("b5", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        dma_last = 1'b1;
        settle();
        chk_gnt("b6", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        dma_req = 1'b0; dma_last = 1'b0;
        settle();
        chk_gnt("bend", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // burst ended by dma_last on beat 2
        dma_req = 1'b1;
        settle();
        chk_gnt("l1", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        cpu_req = 1'b1; dma_last = 1'b1;
        settle();
        chk_gnt("l2", 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        dma_req = 1'b0; dma_last = 1'b0;
        settle();
        chk_gnt("l3", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();

        // abandoned burst: CPU granted while owner still shows DMA_BURST
        cpu_req = 1'b0; dma_req = 1'b1;
        settle();
        chk_gnt("ab1", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        cpu_req = 1'b1; dma_req = 1'b0;
        settle();
        chk_gnt("ab2", 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        settle();
        chk_gnt("ab3", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();

        // reset in the middle of a burst
        cpu_req = 1'b0; dma_req = 1'b1;
        tick();
        tick();
        settle();
        chk_gnt("mr.pre", 1'b0, 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        chk_gnt("mr.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_port("mr.rst", 32'h0, 32'h0, 4'h0);
        dma_req = 1'b0;
        tick();
        reset = 1'b0;
        settle();
        chk_gnt("mr.rel", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mr.burst_cnt", {29'd0, dut.burst_cnt}, 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
